// File: rtl/shift_seq_pkg.sv
// Shared definitions for the Pi serial-load sequencer: FSM states, error codes
// and the register-select decode.
package shift_seq_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        LATCH,
        DRAIN
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_PARITY = 2'd1,
        ERR_SHORT  = 2'd2,
        ERR_ADDR   = 2'd3
    } err_e;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/shift_load_sequencer_sync_edge.sv
// Multi-flop synchroniser for one asynchronous Pi signal, with registered
// level and rising/falling edge pulses that are mutually aligned.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // level, rise and fall all update on the same edge, so rise implies level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/shift_load_sequencer.sv
// Sequences NREG external 8-bit shift registers from the Pi serial load
// interface: steers shift strobes, checks parity and issues the latch strobe.
module shift_load_sequencer
    import shift_seq_pkg::*;
#(
    parameter int NREG        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pi_frame,
    input  logic            pi_sclk,
    input  logic            pi_sdin,
    input  logic [1:0]      pi_rsel,
    input  logic [NREG-1:0] sr_parity,
    output logic [NREG-1:0] sr_select,
    output logic            sr_le,
    output logic            sr_din,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err_code,
    input  logic            err_clr
);

    logic frame_level, frame_rise, frame_fall;
    logic sclk_level, sclk_rise, sclk_fall, sclk_strobe;

    sync_edge #(.STAGES(SYNC_STAGES)) u_frame_sync (
        .clk(clk), .reset(reset), .d(pi_frame),
        .level(frame_level), .rise(frame_rise), .fall(frame_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(pi_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign sclk_strobe = sclk_rise & sclk_level & ~sclk_fall;

    logic [SYNC_STAGES-1:0]   sdin_sync_q, sdin_sync_d;
    logic [2*SYNC_STAGES-1:0] rsel_sync_q, rsel_sync_d;
    logic                     sdin_sync;
    logic [1:0]               rsel_sync;

    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]      rsel_q, rsel_d;
    logic            busy_q, busy_d;
    err_e            err_q, err_d;
    logic [NREG-1:0] sel_q, sel_d;
    logic            le_q, le_d;
    logic            din_q, din_d;
    logic            done_q, done_d;

    logic [3:0]      parity_ext;
    logic [3:0]      sel4;
    logic [NREG-1:0] sel_onehot;

    always_comb begin
        sdin_sync_d = {sdin_sync_q[SYNC_STAGES-2:0], pi_sdin};
        rsel_sync_d = {rsel_sync_q[2*SYNC_STAGES-3:0], pi_rsel};
        parity_ext = '0;
        parity_ext[NREG-1:0] = sr_parity;
        sel4 = onehot4(rsel_q);
        sel_onehot = sel4[NREG-1:0];
    end

    assign sdin_sync = sdin_sync_q[SYNC_STAGES-1];
    assign rsel_sync = rsel_sync_q[2*SYNC_STAGES-1 -: 2];

    // Frame fall is tested before the sclk strobe so a coincident edge is dropped
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rsel_d    = rsel_q;
        busy_d    = busy_q;
        err_d     = err_clr ? ERR_NONE : err_q;
        sel_d     = '0;
        le_d      = 1'b0;
        din_d     = din_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_rise) begin
                    rsel_d = rsel_sync;
                    if (32'(rsel_sync) >= 32'(NREG)) begin
                        err_d   = ERR_ADDR;
                        state_d = DRAIN;
                    end else begin
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (frame_fall) begin
                    err_d   = ERR_SHORT;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_strobe) begin
                    din_d     = sdin_sync;
                    sel_d     = sel_onehot;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (frame_fall) begin
                    err_d   = ERR_SHORT;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_strobe) begin
                    if (sdin_sync == parity_ext[rsel_q]) begin
                        sel_d   = sel_onehot;
                        le_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = LATCH;
                    end else begin
                        err_d   = ERR_PARITY;
                        state_d = DRAIN;
                    end
                end
            end
            LATCH: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!frame_level) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdin_sync_q <= '0;
            rsel_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rsel_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= ERR_NONE;
            sel_q       <= '0;
            le_q        <= 1'b0;
            din_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sdin_sync_q <= sdin_sync_d;
            rsel_sync_q <= rsel_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rsel_q      <= rsel_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            le_q        <= le_d;
            din_q       <= din_d;
            done_q      <= done_d;
        end
    end

    assign sr_select = sel_q;
    assign sr_le     = le_q;
    assign sr_din    = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Directed bench for shift_load_sequencer driving Pi-side frames against a
// behavioural model of the external shift/latch registers.
module tb_shift_load_sequencer;

    localparam int NREG        = 3;
    localparam int SYNC_STAGES = 2;

    logic            clk;
    logic            reset;
    logic            pi_frame;
    logic            pi_sclk;
    logic            pi_sdin;
    logic [1:0]      pi_rsel;
    logic [NREG-1:0] sr_parity;
    logic [NREG-1:0] sr_select;
    logic            sr_le;
    logic            sr_din;
    logic            busy;
    logic            done;
    logic [1:0]      err_code;
    logic            err_clr;

    int total = 0;
    int bad   = 0;

    shift_load_sequencer #(.NREG(NREG), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .pi_frame(pi_frame), .pi_sclk(pi_sclk),
        .pi_sdin(pi_sdin), .pi_rsel(pi_rsel), .sr_parity(sr_parity),
        .sr_select(sr_select), .sr_le(sr_le), .sr_din(sr_din), .busy(busy),
        .done(done), .err_code(err_code), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External registers: shift on select, latch on select+le
    logic [7:0] shf [NREG];
    logic [7:0] lat [NREG];

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (sr_select[i]) begin
                if (sr_le) lat[i] <= shf[i];
                else       shf[i] <= {shf[i][6:0], sr_din};
            end
        end
    end

    always_comb begin
        sr_parity = '0;
        for (int i = 0; i < NREG; i++) sr_parity[i] = ^shf[i];
    end

    int              sel_cnt [NREG] = '{default: 0};
    int              le_cnt   = 0;
    int              done_cnt = 0;
    int              viol     = 0;
    logic [7:0]      din_log  = '0;
    logic [NREG-1:0] le_sel   = '0;

    always @(negedge clk) begin
        for (int i = 0; i < NREG; i++) if (sr_select[i] && !sr_le) sel_cnt[i]++;
        if (sr_select != '0 && !sr_le) din_log = {din_log[6:0], sr_din};
        if (sr_le) begin
            le_cnt++;
            le_sel = sr_select;
        end
        if (done) done_cnt++;
        if ($countones(sr_select) > 1 || (sr_le && sr_select == '0) || (done != sr_le)) viol++;
    end

    task automatic frame_start(input logic [1:0] r);
        pi_rsel = r;
        repeat (3) @(negedge clk);
        pi_frame = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        pi_frame = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pi_bit(input logic b, input logic clr);
        pi_sdin = b;
        repeat (3) @(negedge clk);
        pi_sclk = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (clr && i == 3) err_clr = 1'b1;
            if (i == 4) err_clr = 1'b0;
        end
        pi_sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] data, input logic par, input int first,
                        input int nedges, input logic clr_par);
        logic b;
        for (int i = first; i < nedges; i++) begin
            if (i < 8)       b = data[7-i];
            else if (i == 8) b = par;
            else             b = 1'b0;
            pi_bit(b, clr_par && i == 8);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (sr_select !== '0 || sr_le !== 1'b0 || sr_din !== 1'b0) begin
            bad++; $display("FAIL reset_sr: sel=%b le=%b din=%b want 0", sr_select, sr_le, sr_din);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || err_code !== 2'd0) begin
            bad++; $display("FAIL reset_status: busy=%b done=%b err=%0d want 0", busy, done, err_code);
        end
    endtask

    task automatic test_good_load();
        int b_sel [NREG];
        int b_le;
        int b_done;
        logic [NREG-1:0] exp_sel;
        b_sel = sel_cnt; b_le = le_cnt; b_done = done_cnt;
        frame_start(2'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy: got %b want 1", busy); end
        pi_sdin = 1'b1;
        repeat (3) @(negedge clk);
        pi_sclk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_sel = (i == 3) ? 3'b010 : 3'b000;
            total++; if (sr_select !== exp_sel) begin
                bad++; $display("FAIL latency_%0d: sel=%b want %b", i, sr_select, exp_sel);
            end
        end
        pi_sclk = 1'b0;
        repeat (4) @(negedge clk);
        send(8'hA5, 1'b0, 1, 9, 1'b0);
        total++; if (sel_cnt[1] - b_sel[1] !== 8) begin
            bad++; $display("FAIL good_shifts: got %0d want 8", sel_cnt[1] - b_sel[1]);
        end
        total++; if (din_log !== 8'hA5) begin bad++; $display("FAIL good_din: got %h want a5", din_log); end
        total++; if (le_cnt - b_le !== 1 || le_sel !== 3'b010) begin
            bad++; $display("FAIL good_latch: n=%0d sel=%b want 1 010", le_cnt - b_le, le_sel);
        end
        total++; if (done_cnt - b_done !== 1) begin
            bad++; $display("FAIL good_done: got %0d want 1", done_cnt - b_done);
        end
        total++; if (lat[1] !== 8'hA5 || err_code !== 2'd0) begin
            bad++; $display("FAIL good_reg: reg=%h err=%0d want a5 0", lat[1], err_code);
        end
        frame_end();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_parity_err();
        int b_le;
        frame_start(2'd0);
        send(8'h5A, 1'b0, 0, 9, 1'b0);
        frame_end();
        total++; if (lat[0] !== 8'h5A) begin bad++; $display("FAIL par_pre: reg0=%h want 5a", lat[0]); end
        b_le = le_cnt;
        frame_start(2'd0);
        send(8'h01, 1'b0, 0, 9, 1'b0);
        frame_end();
        total++; if (le_cnt - b_le !== 0 || err_code !== 2'd1) begin
            bad++; $display("FAIL par_err: le=%0d err=%0d want 0 1", le_cnt - b_le, err_code);
        end
        total++; if (lat[0] !== 8'h5A) begin bad++; $display("FAIL par_keep: reg0=%h want 5a", lat[0]); end
        clear_err();
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL par_clr: err=%0d want 0", err_code); end
    endtask

    task automatic test_short_frame();
        int b_sel [NREG];
        int b_le;
        b_sel = sel_cnt; b_le = le_cnt;
        frame_start(2'd2);
        send(8'hB4, 1'b0, 0, 5, 1'b0);
        pi_frame = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL short_early: busy=%b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || err_code !== 2'd2) begin
            bad++; $display("FAIL short_abort: busy=%b err=%0d want 0 2", busy, err_code);
        end
        total++; if (sel_cnt[2] - b_sel[2] !== 5 || le_cnt - b_le !== 0) begin
            bad++; $display("FAIL short_cnt: shifts=%0d le=%0d want 5 0", sel_cnt[2] - b_sel[2], le_cnt - b_le);
        end
        repeat (4) @(negedge clk);
        frame_start(2'd2);
        send(8'h96, 1'b0, 0, 9, 1'b0);
        frame_end();
        total++; if (lat[2] !== 8'h96 || le_cnt - b_le !== 1 || err_code !== 2'd2) begin
            bad++; $display("FAIL short_next: reg2=%h le=%0d err=%0d want 96 1 2", lat[2], le_cnt - b_le, err_code);
        end
    endtask

    task automatic test_bad_addr();
        int b_sel [NREG];
        int b_le;
        int act;
        b_sel = sel_cnt; b_le = le_cnt;
        frame_start(2'd3);
        total++; if (err_code !== 2'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL addr_err: err=%0d busy=%b want 3 0", err_code, busy);
        end
        send(8'h12, 1'b0, 0, 9, 1'b0);
        frame_end();
        act = le_cnt - b_le;
        for (int i = 0; i < NREG; i++) act += sel_cnt[i] - b_sel[i];
        total++; if (act !== 0) begin bad++; $display("FAIL addr_quiet: strobes=%0d want 0", act); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL addr_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_extra_edges();
        int b_sel [NREG];
        int b_le;
        clear_err();
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL extra_clr: err=%0d want 0", err_code); end
        b_sel = sel_cnt; b_le = le_cnt;
        frame_start(2'd0);
        send(8'hFF, 1'b0, 0, 12, 1'b0);
        frame_end();
        total++; if (sel_cnt[0] - b_sel[0] !== 8 || le_cnt - b_le !== 1) begin
            bad++; $display("FAIL extra_cnt: shifts=%0d le=%0d want 8 1", sel_cnt[0] - b_sel[0], le_cnt - b_le);
        end
        total++; if (lat[0] !== 8'hFF) begin bad++; $display("FAIL extra_reg: reg0=%h want ff", lat[0]); end
        frame_start(2'd0);
        send(8'h01, 1'b0, 0, 9, 1'b1);
        frame_end();
        total++; if (err_code !== 2'd1 || lat[0] !== 8'hFF) begin
            bad++; $display("FAIL clr_vs_err: err=%0d reg0=%h want 1 ff", err_code, lat[0]);
        end
    endtask

    task automatic test_reset_mid();
        int b_done;
        frame_start(2'd1);
        send(8'hFF, 1'b0, 0, 4, 1'b0);
        pi_sdin = 1'b1;
        repeat (3) @(negedge clk);
        pi_sclk = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (sr_select !== '0 || sr_le !== 1'b0 || sr_din !== 1'b0 || busy !== 1'b0
                     || done !== 1'b0 || err_code !== 2'd0) begin
            bad++; $display("FAIL mid_reset: sel=%b le=%b din=%b busy=%b done=%b err=%0d want 0",
                            sr_select, sr_le, sr_din, busy, done, err_code);
        end
        pi_frame = 1'b0; pi_sclk = 1'b0; pi_sdin = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (lat[1] !== 8'hA5) begin bad++; $display("FAIL mid_keep: reg1=%h want a5", lat[1]); end
        b_done = done_cnt;
        frame_start(2'd1);
        send(8'h3C, 1'b0, 0, 9, 1'b0);
        frame_end();
        total++; if (lat[1] !== 8'h3C || done_cnt - b_done !== 1 || err_code !== 2'd0) begin
            bad++; $display("FAIL mid_reload: reg1=%h done=%0d err=%0d want 3c 1 0",
                            lat[1], done_cnt - b_done, err_code);
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL strobe_rules: violations=%0d want 0", viol); end
    endtask

    initial begin
        reset = 1'b1; pi_frame = 1'b0; pi_sclk = 1'b0; pi_sdin = 1'b0;
        pi_rsel = 2'd0; err_clr = 1'b0;
        test_reset();
        test_good_load();
        test_parity_err();
        test_short_frame();
        test_bad_addr();
        test_extra_edges();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
